// File: rtl/nsqrt_sched.sv
// Issue controller for the nine-squarer square-root normalization datapath.
// Loads a 9-element vector serially, issues it on credit, and queues tagged magnitudes.
`timescale 1ns/1ps
module nsqrt_sched #(
  parameter int LAT        = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic [89:0]      dp_vec,
  output logic             dp_issue,
  input  logic [10:0]      dp_mag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [10:0]      out_mag,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int NEL = 9;
  localparam int EW  = 10;
  localparam int MW  = 11;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int OW  = $clog2(FIFO_DEPTH + LAT + 1);

  typedef enum logic [1:0] {LOAD, FULL, ISSUE} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [TAG_W-1:0] cur_tag;
  logic [LAT-1:0]   vld_pipe;
  logic [TAG_W-1:0] tag_pipe [LAT];
  logic [MW-1:0]    mem_mag  [FIFO_DEPTH];
  logic [TAG_W-1:0] mem_tag  [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    fifo_count;
  logic [OW-1:0]    occupancy;
  logic             credit_ok, accept, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign accept    = in_valid && in_ready;
  assign push      = vld_pipe[LAT-1];
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;

  // Every slot the FIFO must eventually hold: queued results plus results in flight.
  // NOTE: combinational blocks assign every output first so no path infers a latch.
  always_comb begin
    occupancy = OW'(fifo_count);
    for (int i = 0; i < LAT; i++) occupancy = occupancy + OW'(vld_pipe[i]);
    credit_ok = (occupancy < OW'(FIFO_DEPTH));
  end

  // Credit is also checked on the ninth accept, so an unblocked vector skips FULL
  // and issues in the very next cycle (10 cycles per vector).
  // NOTE: all state is updated with <= so every reader sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      cnt      <= '0;
      cur_tag  <= '0;
      dp_vec   <= '0;
      dp_issue <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (accept) begin
            for (int i = 0; i < NEL; i++)
              if (cnt == 4'(i)) dp_vec[i*EW +: EW] <= in_data;
            if (cnt == '0) cur_tag <= in_tag;
            cnt <= cnt + 4'd1;
            if (cnt == 4'(NEL - 1)) begin
              in_ready <= 1'b0;
              if (credit_ok) begin
                state    <= ISSUE;
                dp_issue <= 1'b1;
              end else begin
                state <= FULL;
              end
            end
          end
        end
        FULL: begin
          if (credit_ok) begin
            state    <= ISSUE;
            dp_issue <= 1'b1;
          end
        end
        ISSUE: begin
          dp_issue <= 1'b0;
          cnt      <= '0;
          in_ready <= 1'b1;
          state    <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

  // In-flight tracker: bit LAT-1 marks the cycle in which dp_mag holds a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < LAT; i++) tag_pipe[i] <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
      vld_pipe[0] <= dp_issue;
      tag_pipe[0] <= cur_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: storage is not reset; the count gates visibility, so stale entries never leak.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_mag[wr_ptr] <= dp_mag;
      mem_tag[wr_ptr] <= tag_pipe[LAT-1];
    end
  end

  assign out_mag = out_valid ? mem_mag[rd_ptr] : '0;
  assign out_tag = out_valid ? mem_tag[rd_ptr] : '0;
  assign busy    = (cnt != '0) || (state != LOAD) || (vld_pipe != '0) || (fifo_count != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (fifo_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_nsqrt_sched.sv
// Directed bench for nsqrt_sched: vector table plus hand-written stall, push/pop and reset sequences.
// The stub datapath returns the element sum LAT cycles after each issue.
`timescale 1ns/1ps
module tb_nsqrt_sched;
  localparam int LAT        = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int TAG_W      = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [9:0]       in_data = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [89:0]      dp_vec;
  logic             dp_issue;
  logic [10:0]      dp_mag;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [10:0]      out_mag;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  nsqrt_sched #(.LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .dp_vec(dp_vec), .dp_issue(dp_issue), .dp_mag(dp_mag),
    .out_valid(out_valid), .out_ready(out_ready), .out_mag(out_mag), .out_tag(out_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [9:0]       base;   // elements are base, base+1, ..., base+8
    logic [10:0]      mag;    // hand-computed 9*base + 36
  } vec_t;

  vec_t tbl [8];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int          issue_q [$];
  logic [10:0] got_mag [$];
  logic [3:0]  got_tag [$];

  logic        force_mag = 1'b0;
  logic [10:0] dly [LAT] = '{default: '0};

  function automatic logic [10:0] sum9(input logic [89:0] v);
    logic [10:0] s;
    s = '0;
    for (int i = 0; i < 9; i++) s = s + 11'(v[i*10 +: 10]);
    return s;
  endfunction

  // Stub datapath and monitor.
  always @(posedge clk) begin
    dly[0] <= dp_issue ? sum9(dp_vec) : 11'h0;
    for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    cyc <= cyc + 1;
    if (dp_issue) issue_q.push_back(cyc);
    if (out_valid && out_ready) begin
      got_mag.push_back(out_mag);
      got_tag.push_back(out_tag);
    end
  end

  assign dp_mag = force_mag ? 11'h7FF : dly[LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] gm(input int k);
    return (k < got_mag.size()) ? got_mag[k] : 11'bx;
  endfunction

  function automatic logic [3:0] gt(input int k);
    return (k < got_tag.size()) ? got_tag[k] : 4'bx;
  endfunction

  function automatic int iq(input int k);
    return (k < issue_q.size()) ? issue_q[k] : -1000;
  endfunction

  task automatic clear_q();
    issue_q.delete();
    got_mag.delete();
    got_tag.delete();
  endtask

  task automatic send_beat(input logic [9:0] d, input logic [TAG_W-1:0] t);
    int budget;
    budget   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = t;
    while (!in_ready && budget < 50) begin
      step();
      budget++;
    end
    if (!in_ready) check("beat accept timeout", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input vec_t v);
    for (int i = 0; i < 9; i++)
      send_beat(v.base + 10'(i), (i == 0) ? v.tag : ~v.tag);
  endtask

  task automatic wait_outs(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (got_mag.size() < n && k < budget) begin
      step();
      k++;
    end
    check(name, got_mag.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    int bad, k;

    tbl[0] = '{tag: 4'd5,  base: 10'd1,   mag: 11'd45};
    tbl[1] = '{tag: 4'd0,  base: 10'd10,  mag: 11'd126};
    tbl[2] = '{tag: 4'd1,  base: 10'd20,  mag: 11'd216};
    tbl[3] = '{tag: 4'd2,  base: 10'd100, mag: 11'd936};
    tbl[4] = '{tag: 4'd15, base: 10'd200, mag: 11'd1836};
    tbl[5] = '{tag: 4'd7,  base: 10'd0,   mag: 11'd36};
    tbl[6] = '{tag: 4'd9,  base: 10'd50,  mag: 11'd486};
    tbl[7] = '{tag: 4'd12, base: 10'd3,   mag: 11'd63};

    // Reset state.
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    step();
    step();
    check("rst in_ready", in_ready, 0);
    check("rst dp_vec", dp_vec, 0);
    check("rst dp_issue", dp_issue, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_mag", out_mag, 0);
    check("rst out_tag", out_tag, 0);
    check("rst busy", busy, 0);
    rst_n = 1'b1;
    step();
    check("post-rst in_ready", in_ready, 1);
    check("post-rst busy", busy, 0);

    // Single vector 1..9, tag 5: issue in cycle 10, result visible in cycle 15.
    clear_q();
    send_vec(tbl[0]);
    check("single issue cyc10", dp_issue, 1);
    check("single dp_vec da", dp_vec[9:0], 1);
    check("single dp_vec di", dp_vec[89:80], 9);
    check("single in_ready low", in_ready, 0);
    step();
    check("single strobe one cycle", dp_issue, 0);
    check("single in_ready back", in_ready, 1);
    step(); step(); step();
    check("single no out cyc14", out_valid, 0);
    step();
    check("single out_valid cyc15", out_valid, 1);
    check("single out_mag", out_mag, tbl[0].mag);
    check("single out_tag", out_tag, tbl[0].tag);
    check("single busy", busy, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single drained", out_valid, 0);
    check("single idle", busy, 0);

    // Three back-to-back vectors with the consumer always ready.
    clear_q();
    out_ready = 1'b1;
    for (int v = 1; v <= 3; v++) send_vec(tbl[v]);
    wait_outs(3, 40, "b2b output count");
    for (int v = 1; v <= 3; v++) begin
      check($sformatf("b2b mag %0d", v), gm(v-1), tbl[v].mag);
      check($sformatf("b2b tag %0d", v), gt(v-1), tbl[v].tag);
    end
    check("b2b issue count", issue_q.size(), 3);
    check("b2b spacing 1", iq(1) - iq(0), 10);
    check("b2b spacing 2", iq(2) - iq(1), 10);
    out_ready = 1'b0;

    // Stalled consumer: two fill the FIFO, the third waits in FULL.
    clear_q();
    send_vec(tbl[4]);
    send_vec(tbl[5]);
    send_vec(tbl[6]);
    bad = 0;
    repeat (10) begin
      if (out_mag !== tbl[4].mag || out_tag !== tbl[4].tag || in_ready !== 1'b0 || dp_issue !== 1'b0)
        bad++;
      step();
    end
    check("stall head stable", bad, 0);
    check("stall issue count", issue_q.size(), 2);
    check("stall out_valid", out_valid, 1);
    check("stall in_ready", in_ready, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("stall pop first", gm(0), tbl[4].mag);
    check("stall new head", out_mag, tbl[5].mag);
    k = 0;
    while (issue_q.size() < 3 && k < 4) begin
      step();
      k++;
    end
    check("stall release issue", issue_q.size(), 3);
    send_vec(tbl[7]);
    out_ready = 1'b1;
    wait_outs(4, 60, "stall output count");
    for (int v = 5; v <= 7; v++) begin
      check($sformatf("stall mag %0d", v), gm(v-4), tbl[v].mag);
      check($sformatf("stall tag %0d", v), gt(v-4), tbl[v].tag);
    end
    check("stall total issues", issue_q.size(), 4);
    out_ready = 1'b0;
    step();

    // Simultaneous push and pop with one entry queued.
    clear_q();
    send_vec(tbl[1]);
    k = 0;
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
    check("pp first queued", out_valid, 1);
    send_vec(tbl[6]);
    check("pp issue", dp_issue, 1);
    step(); step(); step(); step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pp popped A", gm(0), tbl[1].mag);
    check("pp still valid", out_valid, 1);
    check("pp head B mag", out_mag, tbl[6].mag);
    check("pp head B tag", out_tag, tbl[6].tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pp single entry left", out_valid, 0);
    check("pp popped B", gm(1), tbl[6].mag);
    check("pp idle", busy, 0);

    // in_valid toggling: idle beats carry junk data and tags.
    clear_q();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b0;
      in_data  = 10'd999;
      in_tag   = 4'd3;
      step();
      send_beat(tbl[7].base + 10'(i), (i == 0) ? tbl[7].tag : 4'd3);
      if (i == 7) check("toggle no early issue", issue_q.size(), 0);
    end
    check("toggle issue after ninth", dp_issue, 1);
    check("toggle da", dp_vec[9:0], tbl[7].base);
    check("toggle di", dp_vec[89:80], tbl[7].base + 10'd8);
    out_ready = 1'b1;
    wait_outs(1, 20, "toggle output count");
    check("toggle mag", gm(0), tbl[7].mag);
    check("toggle tag", gt(0), tbl[7].tag);
    out_ready = 1'b0;
    step();

    // Reset with a partial vector (3 elements) loaded and one result in flight.
    clear_q();
    send_vec(tbl[5]);
    step();
    for (int i = 0; i < 3; i++) send_beat(tbl[3].base + 10'(i), tbl[3].tag);
    check("pre-rst busy", busy, 1);
    check("pre-rst nothing queued", out_valid, 0);
    rst_n = 1'b0;
    #1;
    check("mid-rst in_ready", in_ready, 0);
    check("mid-rst dp_vec", dp_vec, 0);
    check("mid-rst out_valid", out_valid, 0);
    check("mid-rst busy", busy, 0);
    force_mag = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    check("after-rst in_ready", in_ready, 1);
    bad = 0;
    repeat (8) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
      step();
    end
    check("after-rst no spurious out", bad, 0);
    force_mag = 1'b0;
    clear_q();
    send_vec(tbl[3]);
    out_ready = 1'b1;
    wait_outs(1, 20, "after-rst output count");
    check("after-rst mag", gm(0), tbl[3].mag);
    check("after-rst tag", gt(0), tbl[3].tag);
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
